pe_seq_ctrl: RTL

//   Sequencer for the 512-bit parallel PE. Computes cfg_outs dot products, each cfg_chunks 512-bit chunks long.

---
 rtl/pe_seq_pkg.sv | 18 +
 rtl/pe_seq_addr_gen.sv | 47 ++++
 rtl/pe_seq_ctrl.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/pe_seq_pkg.sv
// Shared types and constants for the PE sequencer.
package pe_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

  // Bit positions inside pe_ctl.
  localparam int PE_CTL_FIRST = 0;
  localparam int PE_CTL_LAST  = 1;

  // Neuron and weight SRAM read latency, in cycles.
  localparam int RD_LAT = 1;

endpackage

// File: rtl/pe_seq_addr_gen.sv
// Chunk / output / linear read counters for the PE sequencer.
// The counters advance once per issued read and are frozen otherwise.
module pe_seq_addr_gen
  import pe_seq_pkg::*;
#(
  parameter int CNT_W = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               adv,
  input  logic [CNT_W-1:0]   cfg_chunks,
  input  logic [CNT_W-1:0]   cfg_outs,
  output logic [CNT_W-1:0]   chunk,
  output logic [2*CNT_W-1:0] lin,
  output logic               first_chunk,
  output logic               last_chunk,
  output logic               last_issue
);

  logic [CNT_W-1:0] out_idx;

  // Step chunk within an output, wrap into the next output, and count the linear weight index.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      chunk   <= '0;
      out_idx <= '0;
      lin     <= '0;
    end else if (adv) begin
      lin <= lin + 1'b1;
      if (last_chunk) begin
        chunk   <= '0;
        out_idx <= out_idx + 1'b1;
      end else begin
        chunk <= chunk + 1'b1;
      end
    end
  end

  // Position flags for the read about to be issued.
  always_comb begin
    first_chunk = (chunk == '0);
    last_chunk  = (chunk == cfg_chunks - 1'b1);
    last_issue  = last_chunk && (out_idx == cfg_outs - 1'b1);
  end

endmodule

// File: rtl/pe_seq_ctrl.sv
// Sequencer for the 512-bit parallel PE: issues neuron/weight SRAM reads,
// aligns pe_vld/pe_ctl with the returned data and writes PE results out.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for start; cfg latched on acceptance
//   RUN   | issuing one neuron+weight read per cycle unless hold
//   DRAIN | all reads issued; waiting for the remaining result writes
//   DONE  | single-cycle done pulse, then back to IDLE
module pe_seq_ctrl
  import pe_seq_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int CNT_W  = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  cfg_chunks,
  input  logic [CNT_W-1:0]  cfg_outs,
  input  logic [ADDR_W-1:0] cfg_nrn_base,
  input  logic [ADDR_W-1:0] cfg_wgt_base,
  input  logic [ADDR_W-1:0] cfg_res_base,
  input  logic              hold,
  output logic              busy,
  output logic              done,
  output logic              nrn_rd_en,
  output logic [ADDR_W-1:0] nrn_rd_addr,
  output logic              wgt_rd_en,
  output logic [ADDR_W-1:0] wgt_rd_addr,
  output logic              pe_vld,
  output logic [1:0]        pe_ctl,
  input  logic              pe_res_vld,
  input  logic [31:0]       pe_result,
  output logic              res_wr_en,
  output logic [ADDR_W-1:0] res_wr_addr,
  output logic [31:0]       res_wr_data
);

  seq_state_t state, state_nxt;

  logic [CNT_W-1:0]  chunks_q, outs_q;
  logic [ADDR_W-1:0] nrn_base_q, wgt_base_q, res_base_q;
  logic [CNT_W-1:0]  res_idx;

  logic              accept;
  logic              issue;
  logic              wr_accept;
  logic [CNT_W-1:0]  chunk;
  logic [2*CNT_W-1:0] lin;
  logic              first_chunk, last_chunk, last_issue;
  logic [1:0]        ctl_issue;

  logic [RD_LAT-1:0]      vld_pipe;
  logic [RD_LAT-1:0][1:0] ctl_pipe;

  assign accept    = (state == IDLE) && start;
  assign issue     = (state == RUN) && !hold;
  assign wr_accept = pe_res_vld && ((state == RUN) || (state == DRAIN));

  pe_seq_addr_gen #(.CNT_W(CNT_W)) u_addr_gen (
    .clk         (clk),
    .rst         (rst),
    .clear       (accept),
    .adv         (issue),
    .cfg_chunks  (chunks_q),
    .cfg_outs    (outs_q),
    .chunk       (chunk),
    .lin         (lin),
    .first_chunk (first_chunk),
    .last_chunk  (last_chunk),
    .last_issue  (last_issue)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Job configuration is captured once per job so mid-job cfg changes are harmless.
  always_ff @(posedge clk) begin
    if (rst) begin
      chunks_q   <= '0;
      outs_q     <= '0;
      nrn_base_q <= '0;
      wgt_base_q <= '0;
      res_base_q <= '0;
    end else if (accept) begin
      chunks_q   <= cfg_chunks;
      outs_q     <= cfg_outs;
      nrn_base_q <= cfg_nrn_base;
      wgt_base_q <= cfg_wgt_base;
      res_base_q <= cfg_res_base;
    end
  end

  // Next-state logic; an empty job skips straight to the done pulse.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          if ((cfg_chunks == '0) || (cfg_outs == '0)) state_nxt = DONE;
          else                                         state_nxt = RUN;
        end
      end
      RUN:     if (issue && last_issue) state_nxt = DRAIN;
      DRAIN:   if (res_idx == outs_q)   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Status and read-port outputs; addresses are zeroed when no read is issued.
  always_comb begin
    busy        = (state != IDLE) || (accept && !rst);
    done        = (state == DONE);
    nrn_rd_en   = issue;
    wgt_rd_en   = issue;
    nrn_rd_addr = '0;
    wgt_rd_addr = '0;
    ctl_issue   = 2'b00;
    if (issue) begin
      nrn_rd_addr             = nrn_base_q + ADDR_W'(chunk);
      wgt_rd_addr             = wgt_base_q + ADDR_W'(lin);
      ctl_issue[PE_CTL_FIRST] = first_chunk;
      ctl_issue[PE_CTL_LAST]  = last_chunk;
    end
  end

  // Delay vld/ctl by the SRAM read latency so they meet the read data at the PE.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      ctl_pipe <= '0;
    end else begin
      vld_pipe[0] <= issue;
      ctl_pipe[0] <= ctl_issue;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        ctl_pipe[i] <= ctl_pipe[i-1];
      end
    end
  end

  assign pe_vld = vld_pipe[RD_LAT-1];
  assign pe_ctl = ctl_pipe[RD_LAT-1];

  // Register each PE result into the result buffer at the next sequential index.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_wr_en   <= 1'b0;
      res_wr_addr <= '0;
      res_wr_data <= '0;
      res_idx     <= '0;
    end else begin
      res_wr_en <= wr_accept;
      if (accept) begin
        res_idx <= '0;
      end else if (wr_accept) begin
        res_wr_addr <= res_base_q + ADDR_W'(res_idx);
        res_wr_data <= pe_result;
        res_idx     <= res_idx + 1'b1;
      end
    end
  end

endmodule
